// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32 instruction patterns, NOP encoding and memory-stage state type.
package riscv_pkg;

    localparam logic [31:0] I_LB  = 32'b????????????_?????_000_?????_0000011;
    localparam logic [31:0] I_LH  = 32'b????????????_?????_001_?????_0000011;
    localparam logic [31:0] I_LW  = 32'b????????????_?????_010_?????_0000011;
    localparam logic [31:0] I_LBU = 32'b????????????_?????_100_?????_0000011;
    localparam logic [31:0] I_LHU = 32'b????????????_?????_101_?????_0000011;
    localparam logic [31:0] S_SB  = 32'b???????_?????_?????_000_?????_0100011;
    localparam logic [31:0] S_SH  = 32'b???????_?????_?????_001_?????_0100011;
    localparam logic [31:0] S_SW  = 32'b???????_?????_?????_010_?????_0100011;
    localparam logic [31:0] R_ALL = 32'b???????_?????_?????_???_?????_0110011;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } mem_state_e;

endpackage

// File: rtl/memory_access_store_steer.sv
// store_steer: byte-lane enables, replicated store data and alignment check from funct3/addr.
module store_steer (
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr,
    input  logic [31:0] rs2,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic        misaligned
);

    logic byte_op;
    logic half_op;

    // Signedness bit is irrelevant to width, so LB/LBU and LH/LHU share a class.
    assign byte_op = funct3 inside {3'b000, 3'b100};
    assign half_op = funct3 inside {3'b001, 3'b101};

    always_comb begin
        be         = byte_op ? 4'b0001 << addr : half_op ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        wdata      = byte_op ? {4{rs2[7:0]}} : half_op ? {2{rs2[15:0]}} : rs2;
        misaligned = byte_op ? 1'b0 : half_op ? addr[0] : |addr;
    end

endmodule

// File: rtl/memory_access.sv
// memory_access: pipeline memory stage issuing one outstanding data-memory access at a time.
module memory_access
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] alu_result_i,
    input  logic [31:0] rs2_data_i,
    output logic        stall_o,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [3:0]  dmem_be_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_gnt_i,
    input  logic        dmem_rvalid_i,
    input  logic [31:0] dmem_rdata_i,
    output logic [31:0] instr_o,
    output logic [31:0] alu_result_o,
    output logic [31:0] data_o,
    output logic        misalign_o
);

    mem_state_e  state, state_d;
    logic        is_load, is_store, is_mem, mis, accept, pass, mem_done;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;
    logic [31:0] instr_q, addr_q, wdata_q;
    logic [3:0]  be_q;
    logic        we_q;
    logic [31:0] instr_d, alu_d, data_d;
    logic        mis_d;

    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        casez (instr_i)
            I_LB, I_LBU, I_LH, I_LHU, I_LW: is_load  = 1'b1;
            S_SB, S_SH, S_SW:               is_store = 1'b1;
            default:                        ;
        endcase
    end

    store_steer u_steer (
        .funct3     (instr_i[14:12]),
        .addr       (alu_result_i[1:0]),
        .rs2        (rs2_data_i),
        .be         (st_be),
        .wdata      (st_wdata),
        .misaligned (mis)
    );

    assign is_mem = is_load | is_store;
    assign accept = state == IDLE && valid_i && is_mem && !mis;
    // Misaligned accesses take the same single-cycle path as non-memory instructions.
    assign pass   = state == IDLE && valid_i && (!is_mem || mis);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    state_d = accept ? REQ : IDLE;
            REQ:     state_d = dmem_gnt_i ? (we_q ? IDLE : WAIT) : REQ;
            WAIT:    state_d = dmem_rvalid_i ? IDLE : WAIT;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_done     = (state == REQ && dmem_gnt_i && we_q) || (state == WAIT && dmem_rvalid_i);
        instr_d      = pass ? instr_i : mem_done ? instr_q : NOP_INSTR;
        alu_d        = pass ? alu_result_i : mem_done ? addr_q : 32'h0;
        data_d       = (state == WAIT && dmem_rvalid_i) ? dmem_rdata_i : 32'h0;
        mis_d        = pass && is_mem;
        stall_o      = state != IDLE;
        dmem_req_o   = state == REQ;
        dmem_we_o    = dmem_req_o && we_q;
        dmem_be_o    = dmem_req_o ? be_q : 4'h0;
        dmem_addr_o  = dmem_req_o ? {addr_q[31:2], 2'b00} : 32'h0;
        dmem_wdata_o = dmem_req_o ? wdata_q : 32'h0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q <= NOP_INSTR;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            be_q    <= 4'h0;
            we_q    <= 1'b0;
        end else if (accept) begin
            instr_q <= instr_i;
            addr_q  <= alu_result_i;
            wdata_q <= is_store ? st_wdata : 32'h0;
            be_q    <= is_store ? st_be : 4'hF;
            we_q    <= is_store;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_o      <= NOP_INSTR;
            alu_result_o <= 32'h0;
            data_o       <= 32'h0;
            misalign_o   <= 1'b0;
        end else begin
            instr_o      <= instr_d;
            alu_result_o <= alu_d;
            data_o       <= data_d;
            misalign_o   <= mis_d;
        end
    end

endmodule

// File: tb/tb_memory_access.sv
// tb_memory_access: table-driven, hand-written and randomized checks of the memory stage.
module tb_memory_access;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid;
    logic [31:0] instr, alu, rs2_d;
    logic        stall, req, we;
    logic [31:0] maddr, wdata;
    logic [3:0]  be;
    logic        gnt, rvalid;
    logic [31:0] rdata;
    logic [31:0] instr_o, alu_o, data_o;
    logic        mis_o;

    int checks = 0;
    int errors = 0;
    int cur_op = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    always #5 clk = ~clk;

    memory_access dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .valid_i       (valid),
        .instr_i       (instr),
        .alu_result_i  (alu),
        .rs2_data_i    (rs2_d),
        .stall_o       (stall),
        .dmem_req_o    (req),
        .dmem_we_o     (we),
        .dmem_addr_o   (maddr),
        .dmem_be_o     (be),
        .dmem_wdata_o  (wdata),
        .dmem_gnt_i    (gnt),
        .dmem_rvalid_i (rvalid),
        .dmem_rdata_i  (rdata),
        .instr_o       (instr_o),
        .alu_result_o  (alu_o),
        .data_o        (data_o),
        .misalign_o    (mis_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL op%0d %s: got %h expected %h", cur_op, name, act, exp);
        end
    endtask

    function automatic logic [31:0] enc(input logic [6:0] op, input logic [2:0] f3);
        return {7'h0, 5'd2, 5'd1, f3, 5'd3, op};
    endfunction

    // Called at a negedge; returns at a negedge after the instruction has completed.
    task automatic run_op(input logic [31:0] ins, addr, rs2, input int gd, rd,
                          input logic [31:0] rd_word, input logic is_mem, st, misa,
                          input logic [3:0] ebe, input logic [31:0] ewd);
        int stalls = 0;
        valid  = 1'b1;
        instr  = ins;
        alu    = addr;
        rs2_d  = rs2;
        gnt    = 1'b0;
        rvalid = 1'($urandom_range(0, 1));
        rdata  = $urandom;
        @(negedge clk);
        valid  = 1'b0;
        instr  = $urandom;
        alu    = $urandom;
        rvalid = 1'b0;
        if (!is_mem || misa) begin
            chk("pass_instr", instr_o, ins);
            chk("pass_alu", alu_o, addr);
            chk("pass_data", data_o, 0);
            chk("pass_mis", mis_o, misa);
            chk("pass_stall", stall, 0);
            chk("pass_req", req, 0);
            @(negedge clk);
            chk("mis_pulse_end", mis_o, 0);
            chk("bubble_after_pass", instr_o, NOP);
        end else begin
            for (int k = 0; k <= gd; k++) begin
                chk("req", req, 1);
                chk("we", we, st);
                chk("addr", maddr, {addr[31:2], 2'b00});
                chk("be", be, ebe);
                chk("wdata", wdata, ewd);
                chk("req_bubble", instr_o, NOP);
                stalls += int'(stall);
                gnt    = (k == gd);
                rvalid = 1'($urandom_range(0, 1));
                rdata  = $urandom;
                @(negedge clk);
                gnt    = 1'b0;
                rvalid = 1'b0;
            end
            if (!st) begin
                for (int k = 0; k <= rd; k++) begin
                    chk("wait_req_low", req, 0);
                    chk("wait_bubble", instr_o, NOP);
                    stalls += int'(stall);
                    gnt    = 1'($urandom_range(0, 1));
                    rvalid = (k == rd);
                    rdata  = (k == rd) ? rd_word : $urandom;
                    @(negedge clk);
                    gnt    = 1'b0;
                    rvalid = 1'b0;
                end
            end
            chk("stall_cycles", stalls, gd + 1 + (st ? 0 : rd + 1));
            chk("done_instr", instr_o, ins);
            chk("done_alu", alu_o, addr);
            chk("done_data", data_o, st ? 32'h0 : rd_word);
            chk("done_stall", stall, 0);
            chk("done_mis", mis_o, 0);
        end
        cur_op++;
    endtask

    typedef struct {
        logic [31:0] ins, addr, rs2;
        int          gd, rd;
        logic [31:0] rdw;
        logic        is_mem, st, mis;
        logic [3:0]  be;
        logic [31:0] wd;
    } vec_t;

    vec_t tbl[12];

    initial begin
        logic [31:0] r, a, s, rw;
        logic [6:0]  op;
        logic [2:0]  f3;
        int          kind, size;
        logic        m, stv, mis;
        logic [3:0]  ebe;
        logic [31:0] ewd;

        tbl[0]  = '{32'h002081B3,        32'h1234, 32'h0,        0, 0, 32'h0,        1'b0, 1'b0, 1'b0, 4'h0, 32'h0};
        tbl[1]  = '{enc(7'h23, 3'b000), 32'h103,  32'hAB,       3, 0, 32'h0,        1'b1, 1'b1, 1'b0, 4'h8, 32'hABABABAB};
        tbl[2]  = '{enc(7'h03, 3'b010), 32'h200,  32'h0,        0, 1, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 4'hF, 32'h0};
        tbl[3]  = '{enc(7'h03, 3'b001), 32'h201,  32'h0,        0, 0, 32'h0,        1'b1, 1'b0, 1'b1, 4'h0, 32'h0};
        tbl[4]  = '{enc(7'h23, 3'b001), 32'h302,  32'h5566,     0, 0, 32'h0,        1'b1, 1'b1, 1'b0, 4'hC, 32'h55665566};
        tbl[5]  = '{enc(7'h23, 3'b010), 32'h104,  32'hCAFEF00D, 1, 0, 32'h0,        1'b1, 1'b1, 1'b0, 4'hF, 32'hCAFEF00D};
        tbl[6]  = '{enc(7'h03, 3'b100), 32'h3,    32'h0,        2, 0, 32'h12345678, 1'b1, 1'b0, 1'b0, 4'hF, 32'h0};
        tbl[7]  = '{enc(7'h03, 3'b010), 32'h6,    32'h0,        0, 0, 32'h0,        1'b1, 1'b0, 1'b1, 4'h0, 32'h0};
        tbl[8]  = '{enc(7'h23, 3'b001), 32'h301,  32'h77,       0, 0, 32'h0,        1'b1, 1'b1, 1'b1, 4'h0, 32'h0};
        tbl[9]  = '{enc(7'h23, 3'b000), 32'h101,  32'h1C7,      0, 0, 32'h0,        1'b1, 1'b1, 1'b0, 4'h2, 32'hC7C7C7C7};
        tbl[10] = '{enc(7'h03, 3'b101), 32'h2,    32'h0,        1, 3, 32'hA5A50F0F, 1'b1, 1'b0, 1'b0, 4'hF, 32'h0};
        tbl[11] = '{enc(7'h23, 3'b010), 32'h2,    32'h99,       0, 0, 32'h0,        1'b1, 1'b1, 1'b1, 4'h0, 32'h0};

        rst_n  = 1'b0;
        valid  = 1'b0;
        instr  = 32'h0;
        alu    = 32'h0;
        rs2_d  = 32'h0;
        gnt    = 1'b0;
        rvalid = 1'b1;
        rdata  = 32'hFFFF_FFFF;
        repeat (2) @(negedge clk);
        chk("rst_instr", instr_o, NOP);
        chk("rst_alu", alu_o, 0);
        chk("rst_data", data_o, 0);
        chk("rst_mis", mis_o, 0);
        chk("rst_req", req, 0);
        chk("rst_we", we, 0);
        chk("rst_be", be, 0);
        chk("rst_addr", maddr, 0);
        chk("rst_wdata", wdata, 0);
        chk("rst_stall", stall, 0);
        rst_n  = 1'b1;
        rvalid = 1'b0;
        @(negedge clk);
        chk("stale_rvalid_ignored", data_o, 0);

        foreach (tbl[i])
            run_op(tbl[i].ins, tbl[i].addr, tbl[i].rs2, tbl[i].gd, tbl[i].rd, tbl[i].rdw,
                   tbl[i].is_mem, tbl[i].st, tbl[i].mis, tbl[i].be, tbl[i].wd);

        // Reset while waiting for load data: stage returns to idle and a late response is dropped.
        valid = 1'b1; instr = enc(7'h03, 3'b010); alu = 32'h400;
        @(negedge clk);
        valid = 1'b0; gnt = 1'b1;
        @(negedge clk);
        gnt = 1'b0;
        chk("wait_stall", stall, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_wait_req", req, 0);
        chk("rst_wait_instr", instr_o, NOP);
        chk("rst_wait_stall", stall, 0);
        @(negedge clk);
        rst_n = 1'b1; rvalid = 1'b1; rdata = 32'h0BAD_0BAD;
        @(negedge clk);
        rvalid = 1'b0;
        chk("late_rvalid_data", data_o, 0);
        chk("late_rvalid_instr", instr_o, NOP);
        chk("late_rvalid_stall", stall, 0);

        // Reset while a store request is pending drops the request at once.
        valid = 1'b1; instr = enc(7'h23, 3'b010); alu = 32'h500; rs2_d = 32'h1;
        @(negedge clk);
        valid = 1'b0;
        chk("req_before_rst", req, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_req_drop", req, 0);
        chk("rst_req_we", we, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_req", req, 0);
        chk("post_rst_stall", stall, 0);

        for (int n = 0; n < 150; n++) begin
            r    = $urandom;
            a    = $urandom;
            s    = $urandom;
            rw   = $urandom;
            kind = $urandom_range(0, 10);
            case (kind)
                0:       begin op = 7'b0110011; f3 = r[14:12]; end
                1:       begin op = 7'b0010011; f3 = r[14:12]; end
                2:       begin op = 7'b0110111; f3 = r[14:12]; end
                3:       begin op = 7'b0000011; f3 = 3'b000; end
                4:       begin op = 7'b0000011; f3 = 3'b001; end
                5:       begin op = 7'b0000011; f3 = 3'b010; end
                6:       begin op = 7'b0000011; f3 = 3'b100; end
                7:       begin op = 7'b0000011; f3 = 3'b101; end
                8:       begin op = 7'b0100011; f3 = 3'b000; end
                9:       begin op = 7'b0100011; f3 = 3'b001; end
                default: begin op = 7'b0100011; f3 = 3'b010; end
            endcase
            m    = kind >= 3;
            stv  = kind >= 8;
            size = 1 << f3[1:0];
            mis  = m && (a % size) != 0;
            ebe  = stv ? 4'(((1 << size) - 1) << a[1:0]) : 4'hF;
            ewd  = !stv ? 32'h0 : size == 1 ? {4{s[7:0]}} : size == 2 ? {2{s[15:0]}} : s;
            run_op({r[31:15], f3, r[11:7], op}, a, s, $urandom_range(0, 3), $urandom_range(0, 3),
                   rw, m, stv, mis, ebe, ewd);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/memory_access.md
# memory_access

Memory stage of the five-stage RISC-V pipeline, between execute and `writeback`. Decodes loads/stores from the instruction word, issues a single outstanding request to data memory over a req/gnt/rvalid handshake, stalls the pipeline until the access completes, and registers instruction, ALU result and raw load word for writeback. Byte/halfword extraction stays in `writeback`. Store lane steering and misalignment detection happen here.

## Interface
- No parameters. Widths are fixed at RV32: 32-bit data and address, 4 byte lanes.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `valid_i` in 1: execute presents a valid instruction.
- `instr_i` in 32: instruction word.
- `alu_result_i` in 32: effective address for loads/stores, result otherwise.
- `rs2_data_i` in 32: store data.
- `stall_o` out 1: stage busy. Upstream holds its outputs while this is high.
- `dmem_req_o` out 1: memory request.
- `dmem_we_o` out 1: 1 = store.
- `dmem_addr_o` out 32: word address, `{alu_result[31:2],2'b00}`.
- `dmem_be_o` out 4: byte enables.
- `dmem_wdata_o` out 32: lane-steered store data.
- `dmem_gnt_i` in 1: request accepted.
- `dmem_rvalid_i` in 1: load data valid.
- `dmem_rdata_i` in 32: load data.
- `instr_o` out 32: instruction to writeback.
- `alu_result_o` out 32: ALU result to writeback.
- `data_o` out 32: raw load word to writeback.
- `misalign_o` out 1: one-cycle pulse on a misaligned access.

## Operation
- FSM states and transitions:
  - IDLE: memory interface quiet.
    - Valid non-memory instruction → outputs registered next edge: `instr_i`, `alu_result_i`, `data_o=0`.
    - Valid aligned load/store → latch instruction, address and lane data; go to REQ.
    - Misaligned access → no request. Pass the instruction through with `data_o=0`, `misalign_o=1`.
  - REQ: `dmem_req_o=1`, all request fields held stable until `dmem_gnt_i`.
    - Store gnt → register outputs, go to IDLE.
    - Load gnt → go to WAIT.
  - WAIT: request dropped. On `dmem_rvalid_i`, register `data_o=dmem_rdata_i` plus the latched instruction and address, then go to IDLE.
- Misalignment rules: LH/LHU/SH with `addr[0]=1`; LW/SW with `addr[1:0]!=0`. LB/LBU/SB are never misaligned.
- Store steering:
  - SB: `be=4'b0001<<addr[1:0]`, `wdata={4{rs2[7:0]}}`.
  - SH: `be=addr[1]?4'b1100:4'b0011`, `wdata={2{rs2[15:0]}}`.
  - SW: `be=4'b1111`, `wdata=rs2`.
- Loads: `be=4'b1111`, `we=0`, `wdata=0`.
- `stall_o = (state != IDLE)`.
- Bubble output whenever nothing completes in a cycle: `instr_o=32'h0000_0013` (NOP), `alu_result_o=0`, `data_o=0`.
- `dmem_rvalid_i` outside WAIT is ignored. This covers stale responses after reset.

## Timing
- Reset values:
  - state IDLE.
  - `dmem_req_o`, `dmem_we_o`, `dmem_be_o`, `dmem_addr_o`, `dmem_wdata_o`, `misalign_o`, `alu_result_o`, `data_o`: all 0.
  - `instr_o=32'h13`.
- Non-memory and misaligned instructions: 1-cycle latency, no stall.
- Stores: accept edge, then `dmem_req_o` high from the next cycle. Output is registered on the gnt edge. Minimum 2 cycles.
- Loads: accept, REQ, then WAIT. `rvalid` is earliest the cycle after gnt. Minimum 3 cycles.
- Gnt in the first REQ cycle is legal. Gnt may be delayed arbitrarily.
- The instruction presented in the accept cycle is consumed. Upstream advances at that same edge and holds the next instruction until `stall_o` falls.
- Reset mid-operation: immediately return to IDLE with `dmem_req_o=0`. The in-flight access is abandoned.
- `misalign_o` is high for exactly one cycle per offending instruction.

## Structure
- Shared `riscv_pkg` holds:
  - instruction casez patterns: `I_LB`, `I_LBU`, `I_LH`, `I_LHU`, `I_LW`, `S_SB`, `S_SH`, `S_SW`, `R_ALL`.
  - `NOP_INSTR`.
  - the state enum `mem_state_e`.
- One natural sub-module, `store_steer`: combinational; takes funct3, `addr[1:0]` and rs2; produces be, wdata and misaligned.

## Test plan
- ADD, `alu_result=32'h1234` → next cycle `instr_o`=ADD, `alu_result_o=32'h1234`, `data_o=0`, no `dmem_req_o`, `stall_o` low.
- SB, `addr=32'h103`, `rs2=32'hAB` → `dmem_addr_o=32'h100`, `be=4'b1000`, `wdata=32'hABABABAB`, `we=1`. Gnt delayed 3 cycles: `stall_o` high for 4 cycles.
- LW, `addr=32'h200`, gnt immediate, rvalid 2 cycles later with `32'hDEADBEEF` → `data_o=32'hDEADBEEF`, `alu_result_o=32'h200`, bubbles before.
- LH, `addr=32'h201` → `misalign_o` pulse, no request, `data_o=0`, no stall.
- SH, `addr=32'h302`, `rs2=32'h5566` → `be=4'b1100`, `wdata=32'h55665566`.
- LW in WAIT, `rst_n` asserted → `dmem_req_o=0`, `instr_o=32'h13`. Later `dmem_rvalid_i` is ignored.
